// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the two links of the VGA raster generator:
//     - mapper link : DrawX/DrawY out to the combinational colour mapper,
//                     Red/Green/Blue back from it.
//     - DAC link    : VGA_CLK, syncs, blank and registered colour to the pins,
//                     plus the pixel_en / frame_start strobes for the system.
//   master : the timing generator (drives coordinates and DAC pins).
//   slave  : the mapper/DAC side (drives colour, observes everything else).
// ----------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pixel_en;
  logic       frame_start;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    input  Red, Green, Blue,
    output DrawX, DrawY, pixel_en, frame_start, VGA_CLK,
           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output Red, Green, Blue,
    input  DrawX, DrawY, pixel_en, frame_start, VGA_CLK,
           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 raster timing generator. Divides the 50 MHz Clk by two into a
//   pixel strobe, runs the horizontal/vertical counters, and registers colour,
//   syncs and blank together so the DAC sees them aligned on the same pixel.
//
//   Ports:
//     Clk    - 50 MHz system clock, all state on the rising edge
//     Reset  - asynchronous, active-high
//     vga    - vga_timing_gen_if.master (mapper link + DAC pins)
//
//   The totals H_* and V_* must each sum to at most 1024 so the 10-bit
//   counters can hold them.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic       p_q;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, vs_q, blank_n_q, frame_start_q;
  logic [7:0] r_q, g_q, b_q;

  logic       h_wrap, v_wrap;
  logic       visible, hs_active, vs_active;

  // NOTE: every signal written here gets a value on every path, so no latch
  // is inferred; defaults come first, overrides after.
  always_comb begin
    h_wrap    = (hc_q == 10'(H_TOTAL - 1));
    v_wrap    = (vc_q == 10'(V_TOTAL - 1));
    hc_d      = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d      = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
    end
    // Output stage looks at the pre-increment counters.
    visible   = (hc_q < 10'(H_VISIBLE)) && (vc_q < 10'(V_VISIBLE));
    hs_active = (hc_q >= 10'(H_SYNC_START)) && (hc_q < 10'(H_SYNC_END));
    vs_active = (vc_q >= 10'(V_SYNC_START)) && (vc_q < 10'(V_SYNC_END));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p_q           <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= ~p_q;
      frame_start_q <= 1'b0;
      if (p_q) begin
        hc_q      <= hc_d;
        vc_q      <= vc_d;
        // Pulse only when the counters wrap into (0,0); reset alone does not.
        if (h_wrap && v_wrap) begin
          frame_start_q <= 1'b1;
        end
        blank_n_q <= visible;
        hs_q      <= ~hs_active;
        vs_q      <= ~vs_active;
        r_q       <= visible ? vga.Red   : 8'd0;
        g_q       <= visible ? vga.Green : 8'd0;
        b_q       <= visible ? vga.Blue  : 8'd0;
      end
    end
  end

  // VGA_CLK is the phase bit: it rises one Clk after the output registers
  // update, giving the DAC a full Clk of setup.
  assign vga.pixel_en    = p_q;
  assign vga.VGA_CLK     = p_q;
  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.frame_start = frame_start_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench. dut_m uses the 640x480 timing for reset, line timing,
//   horizontal blank and colour alignment; dut_s uses a shrunken raster
//   (16x12 total) so whole frames fit in a short run for the vertical sync,
//   vertical blank, frame_start and mid-frame reset checks.
//   Sample points are 2 time units after a rising Clk edge; k counts edges
//   since the most recent reset release.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   hs_low, vs_low, bl_hi, fs_hi;

  always #10 Clk = ~Clk;

  vga_timing_gen_if vga_m ();
  vga_timing_gen_if vga_s ();

  // Mapper stand-ins: Red ramps with the coordinates, Green/Blue held at FF.
  assign vga_m.Red   = vga_m.DrawX[7:0];
  assign vga_m.Green = 8'hFF;
  assign vga_m.Blue  = 8'hFF;
  assign vga_s.Red   = {vga_s.DrawY[3:0], vga_s.DrawX[3:0]};
  assign vga_s.Green = 8'hFF;
  assign vga_s.Blue  = 8'hFF;

  vga_timing_gen dut_m (
    .Clk   (Clk),
    .Reset (rst_m),
    .vga   (vga_m.master)
  );

  // Small raster: H 8/2/3/3 (total 16, sync 10..12), V 6/2/2/2 (total 12,
  // sync lines 8..9). Line = 32 Clk, frame = 384 Clk.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .Clk   (Clk),
    .Reset (rst_s),
    .vga   (vga_s.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset values on the full-size raster ----------------
    cyc(3);
    check("rst_drawx",   vga_m.DrawX, 0);
    check("rst_drawy",   vga_m.DrawY, 0);
    check("rst_pe",      vga_m.pixel_en, 0);
    check("rst_hs",      vga_m.VGA_HS, 1);
    check("rst_vs",      vga_m.VGA_VS, 1);
    check("rst_blank",   vga_m.VGA_BLANK_N, 0);
    check("rst_r",       vga_m.VGA_R, 0);
    check("rst_fs",      vga_m.frame_start, 0);
    check("rst_sync_n",  vga_m.VGA_SYNC_N, 0);
    check("rst_vgaclk",  vga_m.VGA_CLK, 0);

    rst_m = 1'b0;
    #1;
    check("rel_drawx0",  vga_m.DrawX, 0);
    check("rel_pe0",     vga_m.pixel_en, 0);

    // ---------------- two lines of free run ----------------
    hs_low = 0;
    for (int k = 1; k <= 3200; k++) begin
      cyc(1);
      if (k > 1600 && vga_m.VGA_HS == 1'b0) hs_low++;
      case (k)
        1: begin
          check("k1_pe",     vga_m.pixel_en, 1);
          check("k1_vgaclk", vga_m.VGA_CLK, 1);
          check("k1_drawx",  vga_m.DrawX, 0);
        end
        2: begin
          check("k2_pe",     vga_m.pixel_en, 0);
          check("k2_drawx",  vga_m.DrawX, 1);
          check("k2_blank",  vga_m.VGA_BLANK_N, 1);
          check("k2_r",      vga_m.VGA_R, 8'h00);
          check("k2_g",      vga_m.VGA_G, 8'hFF);
        end
        3: check("k3_drawx", vga_m.DrawX, 1);
        4: begin
          check("k4_drawx",  vga_m.DrawX, 2);
          check("k4_r",      vga_m.VGA_R, 8'h01);
        end
        602: begin
          check("px300_r",     vga_m.VGA_R, 8'h2C);
          check("px300_blank", vga_m.VGA_BLANK_N, 1);
          check("px300_hs",    vga_m.VGA_HS, 1);
        end
        1202: check("px600_r", vga_m.VGA_R, 8'h58);
        1281: begin
          check("px639_blank", vga_m.VGA_BLANK_N, 1);
          check("px639_g",     vga_m.VGA_G, 8'hFF);
          check("px639_b",     vga_m.VGA_B, 8'hFF);
          check("px639_r",     vga_m.VGA_R, 8'h7F);
        end
        1282: begin
          check("px640_blank", vga_m.VGA_BLANK_N, 0);
          check("px640_g",     vga_m.VGA_G, 8'h00);
          check("px640_b",     vga_m.VGA_B, 8'h00);
          check("px640_r",     vga_m.VGA_R, 8'h00);
        end
        1313: check("hs_before_fall", vga_m.VGA_HS, 1);
        1314: check("hs_fall",        vga_m.VGA_HS, 0);
        1505: check("hs_before_rise", vga_m.VGA_HS, 0);
        1506: check("hs_rise",        vga_m.VGA_HS, 1);
        1599: begin
          check("eol_drawx", vga_m.DrawX, 799);
          check("eol_drawy", vga_m.DrawY, 0);
        end
        1600: begin
          check("sol_drawx", vga_m.DrawX, 0);
          check("sol_drawy", vga_m.DrawY, 1);
          check("sol_fs",    vga_m.frame_start, 0);
        end
        2913: check("hs2_before_fall", vga_m.VGA_HS, 1);
        2914: begin
          check("hs2_fall", vga_m.VGA_HS, 0);
          check("line1_vs", vga_m.VGA_VS, 1);
        end
        3200: check("line2_drawy", vga_m.DrawY, 2);
        default: ;
      endcase
    end
    check("hs_low_width", hs_low, 192);

    // ---------------- reset mid-pixel at (300,2) ----------------
    cyc(601);
    check("pre_rst_drawx", vga_m.DrawX, 300);
    check("pre_rst_pe",    vga_m.pixel_en, 1);
    check("pre_rst_blank", vga_m.VGA_BLANK_N, 1);
    check("pre_rst_r",     vga_m.VGA_R, 8'h2B);
    rst_m = 1'b1;
    #1;
    check("mid_rst_drawx", vga_m.DrawX, 0);
    check("mid_rst_drawy", vga_m.DrawY, 0);
    check("mid_rst_hs",    vga_m.VGA_HS, 1);
    check("mid_rst_vs",    vga_m.VGA_VS, 1);
    check("mid_rst_r",     vga_m.VGA_R, 0);
    check("mid_rst_g",     vga_m.VGA_G, 0);
    check("mid_rst_blank", vga_m.VGA_BLANK_N, 0);
    check("mid_rst_pe",    vga_m.pixel_en, 0);
    #1;
    rst_m = 1'b0;
    cyc(2);
    check("restart_drawx", vga_m.DrawX, 1);
    check("restart_drawy", vga_m.DrawY, 0);
    rst_m = 1'b1;

    // ---------------- small raster: two frames ----------------
    rst_s = 1'b0;
    vs_low = 0;
    bl_hi  = 0;
    fs_hi  = 0;
    for (int k = 1; k <= 800; k++) begin
      cyc(1);
      if (k <= 384) begin
        if (vga_s.VGA_VS == 1'b0) vs_low++;
        if (vga_s.VGA_BLANK_N == 1'b1) bl_hi++;
      end
      if (vga_s.frame_start == 1'b1) fs_hi++;
      case (k)
        21:  check("s_hs_before_fall", vga_s.VGA_HS, 1);
        22:  check("s_hs_fall",        vga_s.VGA_HS, 0);
        27:  check("s_hs_before_rise", vga_s.VGA_HS, 0);
        28:  check("s_hs_rise",        vga_s.VGA_HS, 1);
        176: begin
          check("s_px7_5_blank", vga_s.VGA_BLANK_N, 1);
          check("s_px7_5_r",     vga_s.VGA_R, 8'h57);
          check("s_px7_5_g",     vga_s.VGA_G, 8'hFF);
        end
        178: check("s_px8_5_blank", vga_s.VGA_BLANK_N, 0);
        194: begin
          check("s_px0_6_blank", vga_s.VGA_BLANK_N, 0);
          check("s_px0_6_g",     vga_s.VGA_G, 8'h00);
        end
        257: check("s_vs_before_fall", vga_s.VGA_VS, 1);
        258: check("s_vs_fall",        vga_s.VGA_VS, 0);
        321: check("s_vs_before_rise", vga_s.VGA_VS, 0);
        322: check("s_vs_rise",        vga_s.VGA_VS, 1);
        383: check("s_fs_before", vga_s.frame_start, 0);
        384: begin
          check("s_fs_pulse", vga_s.frame_start, 1);
          check("s_wrap_x",   vga_s.DrawX, 0);
          check("s_wrap_y",   vga_s.DrawY, 0);
        end
        385: check("s_fs_after", vga_s.frame_start, 0);
        default: ;
      endcase
    end
    check("s_vs_low_width", vs_low, 64);
    check("s_blank_n_hi",   bl_hi, 96);
    check("s_fs_count",     fs_hi, 2);

    // ---------------- small raster: reset during vertical sync ----------------
    cyc(228);
    check("s_pre_rst_drawy", vga_s.DrawY, 8);
    check("s_pre_rst_vs",    vga_s.VGA_VS, 0);
    rst_s = 1'b1;
    #1;
    check("s_rst_vs",    vga_s.VGA_VS, 1);
    check("s_rst_hs",    vga_s.VGA_HS, 1);
    check("s_rst_drawx", vga_s.DrawX, 0);
    check("s_rst_drawy", vga_s.DrawY, 0);
    check("s_rst_blank", vga_s.VGA_BLANK_N, 0);
    check("s_rst_fs",    vga_s.frame_start, 0);
    #1;
    rst_s = 1'b0;
    fs_hi = 0;
    for (int k = 1; k <= 384; k++) begin
      cyc(1);
      if (k < 384 && vga_s.frame_start == 1'b1) fs_hi++;
      if (k == 384) check("s_first_fs_after_rst", vga_s.frame_start, 1);
    end
    check("s_no_fs_at_release", fs_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
